// File: rtl/alu_ctrl_pc.sv
// ALU control decoder, 8-bit ALU and free-running program counter.
// Optional macro ALU_EXT_OPS_EN adds XOR, SLL and SRL decodes and ALU operations.
module alu_ctrl_pc #(
  parameter int          PC_STEP  = 4,
  parameter logic [7:0]  PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] readdata1,
  input  logic [7:0] y,
  input  logic [3:0] func,
  input  logic [1:0] Aluop,
  output logic [3:0] aluopc,
  output logic [7:0] result,
  output logic       zero,
  output logic [7:0] pcout
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_EXT_OPS_EN
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
`endif

  localparam logic [7:0] PC_INC = 8'(PC_STEP);

  logic [3:0] w_func;
  logic       w_slt;
  logic [7:0] r_pc;

  // Aluop=11 is the immediate form: funct7[5] carries no meaning there.
  assign w_func = (Aluop == 2'b11) ? {1'b0, func[2:0]} : func;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    aluopc = OP_ADD;
    unique case (Aluop)
      2'b00: aluopc = OP_ADD;
      2'b01: aluopc = OP_SUB;
      default: begin
        case (w_func)
          4'b0000: aluopc = OP_ADD;
          4'b1000: aluopc = OP_SUB;
          4'b0111: aluopc = OP_AND;
          4'b0110: aluopc = OP_OR;
          4'b0010: aluopc = OP_SLT;
`ifdef ALU_EXT_OPS_EN
          4'b0100: aluopc = OP_XOR;
          4'b0001: aluopc = OP_SLL;
          4'b0101: aluopc = OP_SRL;
`endif
          default: aluopc = OP_ADD;
        endcase
      end
    endcase
  end

  assign w_slt = $signed(readdata1) < $signed(y);

  always_comb begin
    result = 8'h00;
    case (aluopc)
      OP_AND:  result = readdata1 & y;
      OP_OR:   result = readdata1 | y;
      OP_ADD:  result = readdata1 + y;
      OP_SUB:  result = readdata1 - y;
      OP_SLT:  result = {7'b0, w_slt};
      OP_NOR:  result = ~(readdata1 | y);
`ifdef ALU_EXT_OPS_EN
      OP_XOR:  result = readdata1 ^ y;
      OP_SLL:  result = readdata1 << y[2:0];
      OP_SRL:  result = readdata1 >> y[2:0];
`endif
      default: result = 8'h00;
    endcase
  end

  assign zero = (result == 8'h00);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pc <= PC_RESET;
    else       r_pc <= r_pc + PC_INC;
  end

  assign pcout = r_pc;

endmodule

// File: tb/tb_alu_ctrl_pc.sv
// Scoreboard bench for alu_ctrl_pc: stimulus pushes expectations, a negedge monitor pops and compares.
// Expectations for the ALU_EXT_OPS_EN decodes follow the same macro.
module tb_alu_ctrl_pc;

  localparam logic [7:0] PC_RST = 8'h00;
  localparam logic [7:0] STEP   = 8'h04;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] readdata1, y;
  logic [3:0] func;
  logic [1:0] Aluop;
  logic [3:0] aluopc;
  logic [7:0] result;
  logic       zero;
  logic [7:0] pcout;

  alu_ctrl_pc #(.PC_STEP(4), .PC_RESET(8'h00)) dut (
    .clk(clk), .reset(reset), .readdata1(readdata1), .y(y), .func(func),
    .Aluop(Aluop), .aluopc(aluopc), .result(result), .zero(zero), .pcout(pcout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         chk_alu;
    logic [3:0] e_opc;
    logic [7:0] e_res;
    logic       e_zero;
    logic [7:0] e_pc;
  } item_t;

  item_t      sb_q[$];
  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_pc;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, half a cycle after stimulus settles.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      item_t it;
      it = sb_q.pop_front();
      check({it.name, ".pc"}, pcout, it.e_pc);
      if (it.chk_alu) begin
        check({it.name, ".opc"},  {4'b0, aluopc}, {4'b0, it.e_opc});
        check({it.name, ".res"},  result, it.e_res);
        check({it.name, ".zero"}, {7'b0, zero}, {7'b0, it.e_zero});
      end
    end
  end

  task automatic issue(input string name, input logic [1:0] op, input logic [3:0] fn,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] e_opc, input logic [7:0] e_res);
    item_t it;
    @(posedge clk);
    exp_pc = exp_pc + STEP;
    #1;
    Aluop = op; func = fn; readdata1 = a; y = b;
    it.name = name; it.chk_alu = 1'b1; it.e_opc = e_opc; it.e_res = e_res;
    it.e_zero = (e_res == 8'h00); it.e_pc = exp_pc;
    sb_q.push_back(it);
  endtask

  task automatic issue_pc();
    item_t it;
    @(posedge clk);
    exp_pc = exp_pc + STEP;
    #1;
    it.name = "pc_run"; it.chk_alu = 1'b0; it.e_opc = 4'b0; it.e_res = 8'h00;
    it.e_zero = 1'b0; it.e_pc = exp_pc;
    sb_q.push_back(it);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t it0;
    reset = 1'b1; readdata1 = 8'h00; y = 8'h00; func = 4'b0000; Aluop = 2'b00;
    exp_pc = PC_RST;
    #3;
    check("pc_in_reset", pcout, PC_RST);
    #3;
    reset = 1'b0;
    it0.name = "pc_after_release"; it0.chk_alu = 1'b0; it0.e_opc = 4'b0; it0.e_res = 8'h00;
    it0.e_zero = 1'b0; it0.e_pc = exp_pc;
    sb_q.push_back(it0);

    issue("add_r",    2'b10, 4'b0000, 8'h05, 8'h03, 4'b0010, 8'h08);
    issue("sub_r",    2'b10, 4'b1000, 8'h05, 8'h03, 4'b0110, 8'h02);
    issue("beq_eq",   2'b01, 4'b0000, 8'h2A, 8'h2A, 4'b0110, 8'h00);
    issue("ldst_wrap",2'b00, 4'b0000, 8'hFF, 8'h01, 4'b0010, 8'h00);

    // Asynchronous reset in mid-count: takes effect before any clock edge.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("pc_async_reset", pcout, PC_RST);
    exp_pc = PC_RST;
    @(posedge clk);
    #1;
    check("pc_hold_reset", pcout, PC_RST);
    #2;
    reset = 1'b0;

    issue("and_r",    2'b10, 4'b0111, 8'hF0, 8'h3C, 4'b0000, 8'h30);
    issue("or_r",     2'b10, 4'b0110, 8'hF0, 8'h3C, 4'b0001, 8'hFC);
    issue("slt_true", 2'b10, 4'b0010, 8'h80, 8'h01, 4'b0111, 8'h01);
    issue("slt_false",2'b10, 4'b0010, 8'h01, 8'h80, 4'b0111, 8'h00);
    issue("sub_neg",  2'b01, 4'b0000, 8'h03, 8'h05, 4'b0110, 8'hFE);
    issue("undef_r",  2'b10, 4'b0011, 8'h05, 8'h03, 4'b0010, 8'h08);
    issue("f3_r",     2'b10, 4'b1111, 8'h05, 8'h03, 4'b0010, 8'h08);
    issue("and_i",    2'b11, 4'b1111, 8'h05, 8'h03, 4'b0000, 8'h01);
    issue("or_i",     2'b11, 4'b1110, 8'h41, 8'h12, 4'b0001, 8'h53);

    while (exp_pc != 8'hF4) issue_pc();
    issue_pc();
    issue("addi_f7",  2'b11, 4'b1000, 8'h05, 8'h03, 4'b0010, 8'h08);
`ifdef ALU_EXT_OPS_EN
    issue("sll_r",    2'b10, 4'b0001, 8'h01, 8'h03, 4'b0100, 8'h08);
    issue("xor_r",    2'b10, 4'b0100, 8'hF0, 8'h3C, 4'b0011, 8'hCC);
    issue("srl_i",    2'b11, 4'b0101, 8'h80, 8'h03, 4'b0101, 8'h10);
`else
    issue("sll_r",    2'b10, 4'b0001, 8'h01, 8'h03, 4'b0010, 8'h04);
    issue("xor_r",    2'b10, 4'b0100, 8'hF0, 8'h3C, 4'b0010, 8'h2C);
    issue("srl_i",    2'b11, 4'b0101, 8'h80, 8'h03, 4'b0010, 8'h83);
`endif

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
